// File: rtl/fft_reorder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_reorder_pkg                                                            |
// | Shared definitions for the bit-reversal reorder buffer: default frame      |
// | geometry, frame-length helper, bank-index type and bit-reversal function.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fft_reorder_pkg;

  localparam int DEF_N_LOG2    = 3;
  localparam int DEF_FRAME_LEN = 1 << DEF_N_LOG2;

  // Selects one of the two ping-pong banks.
  typedef logic bank_idx_t;

  function automatic int frame_len(input int n_log2);
    return 1 << n_log2;
  endfunction

  // Reverses the low n_log2 bits of addr; bits above n_log2 come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] addr, input int n_log2);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n_log2) r[i] = addr[n_log2-1-i];
    end
    return r;
  endfunction

endpackage : fft_reorder_pkg
`default_nettype wire

// File: rtl/fft_reorder_bit_rev.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bit_rev                                                                    |
// | Purely combinational bit-order reversal of a W-bit address.                |
// | Ports:                                                                     |
// |   addr_in  in  W  natural-order address                                    |
// |   addr_out out W  addr_in with bit order reversed                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bit_rev #(
  parameter int W = 3
) (
  input  logic [W-1:0] addr_in,
  output logic [W-1:0] addr_out
);

  for (genvar i = 0; i < W; i++) begin : g_rev
    assign addr_out[i] = addr_in[W-1-i];
  end

endmodule : bit_rev
`default_nettype wire

// File: rtl/fft_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_reorder                                                                |
// | Ping-pong bit-reversal reorder buffer. Takes a frame of 2^N_LOG2 samples   |
// | in bit-reversed order and emits it in natural order, one sample per cycle. |
// | Optional feature macro: FFT_REORDER_LAST_EN (adds out_last).               |
// | Ports:                                                                     |
// |   clk       in   1       rising-edge clock                                 |
// |   clear     in   1       asynchronous active-low reset                     |
// |   in_valid  in   1       in_data holds a sample                            |
// |   in_ready  out  1       buffer accepts a sample this cycle                |
// |   in_data   in   DATA_W  sample, bit-reversed arrival order                |
// |   out_valid out  1       out_data holds a sample                           |
// |   out_ready in   1       sink accepts out_data this cycle                  |
// |   out_data  out  DATA_W  sample, natural order                             |
// |   out_last  out  1       last sample of frame (FFT_REORDER_LAST_EN only)   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fft_reorder
  import fft_reorder_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int N_LOG2 = 3
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef FFT_REORDER_LAST_EN
  ,
  output logic              out_last
`endif
);

  localparam int N = frame_len(N_LOG2);

  logic [DATA_W-1:0] mem [2][N];
  logic [1:0]        full;
  bank_idx_t         wbank;
  bank_idx_t         rbank;
  logic [N_LOG2-1:0] wcnt;
  logic [N_LOG2-1:0] rcnt;
  logic [N_LOG2-1:0] waddr;
  logic              wr_fire;
  logic              rd_fire;

  // Reversal sits on the write side so the read side is a plain counter.
  bit_rev #(.W(N_LOG2)) u_bit_rev (
    .addr_in  (wcnt),
    .addr_out (waddr)
  );

  // Both handshakes depend only on flops plus the partner's valid/ready,
  // so no input reaches an output combinationally.
  assign in_ready  = !full[wbank];
  assign out_valid = full[rbank];
  assign out_data  = mem[rbank][rcnt];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

`ifdef FFT_REORDER_LAST_EN
  assign out_last = out_valid && (&rcnt);
`endif

  // Write completion and read completion may land on the same edge; they
  // always touch different full bits since writes target a non-full bank
  // and reads a full one.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      full  <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      wcnt  <= '0;
      rcnt  <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int a = 0; a < N; a++) begin
          mem[b][a] <= '0;
        end
      end
    end else begin
      if (wr_fire) begin
        mem[wbank][waddr] <= in_data;
        wcnt              <= wcnt + 1'b1;
        if (&wcnt) begin
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
        end
      end
      if (rd_fire) begin
        rcnt <= rcnt + 1'b1;
        if (&rcnt) begin
          full[rbank] <= 1'b0;
          rbank       <= ~rbank;
        end
      end
    end
  end

endmodule : fft_reorder
`default_nettype wire

// File: tb/tb_fft_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fft_reorder                                                             |
// | Self-checking bench for fft_reorder (N=8, DATA_W=4): reset values, single |
// | frame table, continuous streaming, backpressure, random stalls, mid-frame  |
// | reset and, with FFT_REORDER_LAST_EN, out_last placement.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fft_reorder;

  logic       clk = 1'b0;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last_w;

  always #5 clk = ~clk;

  fft_reorder #(.DATA_W(4), .N_LOG2(3)) dut (
    .clk       (clk),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FFT_REORDER_LAST_EN
    ,
    .out_last  (out_last_w)
`endif
  );

`ifndef FFT_REORDER_LAST_EN
  assign out_last_w = 1'b0;
`endif

  typedef struct {
    logic       iv;
    logic [3:0] id;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [3:0] e_od;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  int         br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [3:0] exp_q[$];
  logic [3:0] fb[8];
  logic [3:0] src[64];
  vec_t       tbl[17];
  int         wpos, rdpos, idx, reads, cyc, ir_drops, gaps;
  logic       prev_stall;
  logic [3:0] prev_data;
  logic       s_ir, s_ov, s_ol;
  logic [3:0] s_od;
  bit         acc_in, acc_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    wpos = 0; rdpos = 0; idx = 0; reads = 0; cyc = 0;
    ir_drops = 0; gaps = 0; prev_stall = 1'b0; prev_data = '0;
  endtask

  // Inputs are already driven; sample on the falling edge, update the
  // reference model with whatever handshakes complete, then step past the
  // next rising edge.
  task automatic cycle();
    @(negedge clk);
    s_ir = in_ready; s_ov = out_valid; s_od = out_data; s_ol = out_last_w;
    if (prev_stall) begin
      chk("stall_hold_valid", 32'(s_ov), 1);
      chk("stall_hold_data", 32'(s_od), 32'(prev_data));
    end
`ifdef FFT_REORDER_LAST_EN
    chk("out_last", 32'(s_ol), 32'(s_ov && rdpos == 7));
`endif
    acc_in  = in_valid && s_ir;
    acc_out = s_ov && out_ready;
    if (in_valid && !s_ir) ir_drops++;
    if (acc_in) begin
      fb[br[wpos]] = in_data;
      if (wpos == 7) begin
        for (int k = 0; k < 8; k++) exp_q.push_back(fb[k]);
        wpos = 0;
      end else begin
        wpos++;
      end
    end
    if (acc_out) begin
      if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
      else chk("out_data", 32'(s_od), 32'(exp_q.pop_front()));
      rdpos = (rdpos + 1) % 8;
      reads++;
    end
    prev_stall = s_ov && !out_ready;
    prev_data  = s_od;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n_in, input int n_out, input bit rnd, input int budget);
    int t;
    int r0;
    t = 0;
    while ((idx < n_in || reads < n_out) && t < budget) begin
      in_valid  = (idx < n_in) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      in_data   = in_valid ? src[idx] : 4'd0;
      out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      r0 = reads;
      cycle();
      if (r0 > 0 && r0 < n_out && !s_ov) gaps++;
      if (acc_in) idx++;
      t++;
    end
    in_valid = 1'b0;
    chk("run_within_budget", 32'(idx >= n_in && reads >= n_out), 1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    clear = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last_w), 0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic setv(input int i, input bit iv, input int id, input bit ordy,
                      input bit eir, input bit eov, input int eod);
    tbl[i].iv = iv; tbl[i].id = 4'(id); tbl[i].ordy = ordy;
    tbl[i].e_ir = eir; tbl[i].e_ov = eov; tbl[i].e_od = 4'(eod);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #2;

    // Single frame: 0,4,2,6,1,5,3,7 in, 0..7 out on consecutive cycles.
    do_reset();
    for (int k = 0; k < 8; k++) setv(k, 1, br[k], 1, 1, 0, 0);
    for (int k = 0; k < 8; k++) setv(8 + k, 0, 0, 1, 1, 1, k);
    setv(16, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 17; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
      cycle();
      chk($sformatf("tbl%0d_in_ready", i), 32'(s_ir), 32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_out_valid", i), 32'(s_ov), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), 32'(s_od), 32'(tbl[i].e_od));
    end

    // Continuous streaming: 4 frames, no stalls either side.
    do_reset();
    for (int i = 0; i < 32; i++) src[i] = 4'(i * 5 + 3);
    run(32, 32, 1'b0, 100);
    chk("stream_in_ready_drops", 32'(ir_drops), 0);
    chk("stream_out_gaps", 32'(gaps), 0);
    chk("stream_total_cycles", 32'(cyc), 40);
    chk("stream_leftover", 32'(exp_q.size()), 0);

    // Backpressure: sink stalled while three frames are offered.
    do_reset();
    for (int i = 0; i < 24; i++) src[i] = 4'(i * 7 + 1);
    for (int t = 0; t < 20; t++) begin
      in_valid = 1'b1; in_data = src[idx]; out_ready = 1'b0;
      cycle();
      if (acc_in) idx++;
    end
    chk("bp_accepted", 32'(idx), 16);
    chk("bp_in_ready_low", 32'(s_ir), 0);
    chk("bp_out_valid", 32'(s_ov), 1);
    for (int t = 0; t < 20 && reads < 8; t++) begin
      in_valid = 1'b1; in_data = src[idx]; out_ready = 1'b1;
      cycle();
      if (acc_in) idx++;
    end
    chk("bp_reads", 32'(reads), 8);
    chk("bp_17th_held", 32'(idx), 16);
    chk("bp_in_ready_back", 32'(in_ready), 1);
    run(24, 24, 1'b0, 100);
    chk("bp_leftover", 32'(exp_q.size()), 0);

    // Random stalls on both sides.
    do_reset();
    for (int i = 0; i < 32; i++) src[i] = 4'($urandom_range(0, 15));
    run(32, 32, 1'b1, 800);
    chk("rnd_reads", 32'(reads), 32);
    chk("rnd_leftover", 32'(exp_q.size()), 0);

    // Reset while frame 0 drains and frame 1 is partly written.
    do_reset();
    for (int i = 0; i < 16; i++) src[i] = 4'(i + 2);
    for (int t = 0; t < 40 && idx < 13; t++) begin
      in_valid = 1'b1; in_data = src[idx]; out_ready = 1'b1;
      cycle();
      if (acc_in) idx++;
    end
    chk("mid_reads_before", 32'(reads), 5);
    in_valid = 1'b0;
    #3;
    clear = 1'b0;
    #1;
    chk("mid_out_valid", 32'(out_valid), 0);
    chk("mid_in_ready", 32'(in_ready), 1);
    chk("mid_out_data", 32'(out_data), 0);
    @(posedge clk);
    #1;
    clear = 1'b1;
    model_reset();
    for (int k = 0; k < 8; k++) src[k] = 4'(8 + br[k]);
    run(8, 8, 1'b0, 40);
    chk("mid_fresh_reads", 32'(reads), 8);
    chk("mid_leftover", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fft_reorder
`default_nettype wire
